nios2os_st_fifo_arbiter: RTL

Packet-granular round-robin arbiter that shares one Avalon-ST timing-adapter FIFO (42-bit beats, 5-bit fill level) between NUM_IN streaming sources. It sits directly upstream of the FIFO's data_in interface. It grants one source at a time for a whole packet, from startofpacket to endofpacket. An optional fill-level gate holds off new grants while the FIFO is nearly full.

---
 rtl/nios2os_st_fifo_arbiter_pkg.sv | 14 +
 rtl/nios2os_st_fifo_arbiter_rr_pick.sv | 28 ++
 rtl/nios2os_st_fifo_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/nios2os_st_fifo_arbiter_pkg.sv
// nios2os_st_arb_pkg: shared state encoding, beat layout and counter width for the FIFO arbiter
package nios2os_st_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam int DEF_PAYLOAD_WIDTH = 40;
    localparam int SOP_BIT           = DEF_PAYLOAD_WIDTH + 1;
    localparam int EOP_BIT           = DEF_PAYLOAD_WIDTH;
    localparam int PKT_CNT_W         = 16;

endpackage

// File: rtl/nios2os_st_fifo_arbiter_rr_pick.sv
// nios2os_rr_pick: combinational round-robin search starting just after last_i, wrapping modulo NUM_IN
module nios2os_rr_pick #(
    parameter int NUM_IN = 4,
    parameter int LW     = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [LW-1:0]     last_i,
    output logic [NUM_IN-1:0] win_o,
    output logic              found_o
);

    logic [LW-1:0] k;

    // first requester encountered walking upward from last_i+1 wins
    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        k       = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            k = LW'((int'(last_i) + i) % NUM_IN);
            if (!found_o && req_i[k]) begin
                win_o[k] = 1'b1;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2os_st_fifo_arbiter.sv
// nios2os_st_fifo_arbiter: packet-granular round-robin arbiter in front of a shared Avalon-ST FIFO
// Optional fill-level gate on new grants: define NIOS2OS_ST_ARB_FILL_GATE_EN
module nios2os_st_fifo_arbiter
    import nios2os_st_arb_pkg::*;
#(
    parameter int NUM_IN        = 4,
    parameter int PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH,
    parameter int FILL_WIDTH    = 5,
    parameter int START_THRESH  = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_IN-1:0]               in_valid,
    output logic [NUM_IN-1:0]               in_ready,
    input  logic [NUM_IN*PAYLOAD_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]               in_sop,
    input  logic [NUM_IN-1:0]               in_eop,
    input  logic                            fifo_in_ready,
    output logic                            fifo_in_valid,
    output logic [PAYLOAD_WIDTH+1:0]        fifo_in_data,
    input  logic [FILL_WIDTH-1:0]           fifo_fill_level,
    output logic [NUM_IN-1:0]               grant,
    output logic                            busy,
    output logic [PKT_CNT_W-1:0]            pkt_count,
    output logic                            proto_err
);

    localparam int LW    = $clog2(NUM_IN);
    localparam int SOP_L = SOP_BIT + PAYLOAD_WIDTH - DEF_PAYLOAD_WIDTH;
    localparam int EOP_L = EOP_BIT + PAYLOAD_WIDTH - DEF_PAYLOAD_WIDTH;

    state_e                 state_q, state_d;
    logic [LW-1:0]          owner_q, owner_d, last_q, last_d, win_idx;
    logic [NUM_IN-1:0]      grant_q, grant_d, win;
    logic [PKT_CNT_W-1:0]   pkt_q, pkt_d;
    logic                   first_q, first_d, err_q, err_d;
    logic                   found, gate, acc;
    logic                   own_valid, own_sop, own_eop;
    logic [PAYLOAD_WIDTH-1:0] own_data;

`ifdef NIOS2OS_ST_ARB_FILL_GATE_EN
    assign gate = fifo_fill_level <= FILL_WIDTH'(START_THRESH);
`else
    logic unused_fill;
    assign gate        = 1'b1;
    assign unused_fill = ^fifo_fill_level;
`endif

    nios2os_rr_pick #(.NUM_IN(NUM_IN), .LW(LW)) u_pick (
        .req_i   (in_valid),
        .last_i  (last_q),
        .win_o   (win),
        .found_o (found)
    );

    // select the owner's beat and encode the one-hot winner as an index
    always_comb begin
        own_valid = 1'b0;
        own_sop   = 1'b0;
        own_eop   = 1'b0;
        own_data  = '0;
        win_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (owner_q == LW'(i)) begin
                own_valid = in_valid[i];
                own_sop   = in_sop[i];
                own_eop   = in_eop[i];
                own_data  = in_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
            if (win[i]) win_idx = LW'(i);
        end
    end

    assign acc = (state_q == XFER) && own_valid && fifo_in_ready;

    // state and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LW'(NUM_IN - 1);
            grant_q <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            first_q <= first_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    // grant in IDLE when the gate is open; release on an accepted eop beat
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        first_d = first_q;
        err_d   = err_q;
        pkt_d   = pkt_q;
        if (state_q == IDLE) begin
            if (found && gate) begin
                state_d = XFER;
                owner_d = win_idx;
                grant_d = win;
                first_d = 1'b1;
            end
        end else if (acc) begin
            first_d = 1'b0;
            if (own_sop != first_q) err_d = 1'b1;
            if (own_eop) begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = owner_q;
                pkt_d   = pkt_q + PKT_CNT_W'(1);
            end
        end
    end

    // combinational pass-through of the owner's stream while a packet is in progress
    always_comb begin
        busy                             = state_q == XFER;
        fifo_in_valid                    = busy && own_valid;
        fifo_in_data[SOP_L]              = own_sop;
        fifo_in_data[EOP_L]              = own_eop;
        fifo_in_data[PAYLOAD_WIDTH-1:0]  = own_data;
        in_ready                         = (busy && fifo_in_ready) ? grant_q : '0;
        grant                            = grant_q;
        pkt_count                        = pkt_q;
        proto_err                        = err_q;
    end

endmodule
